// File: rtl/conv_stream_out.sv
// conv_stream_out: output stage for the 4-pixel convolver.
// Realigns the input-side valid with the convolver result, drops the warm-up
// words at the start of each frame, tags the final word of each frame, and
// buffers results in a small first-word-fall-through FIFO that drives an
// AXI-Stream master interface toward the DMA.
module conv_stream_out #(
    parameter int NB_DATA      = 32,
    parameter int CONV_LATENCY = 2,
    parameter int SKIP_WORDS   = 100,
    parameter int FRAME_WORDS  = 9800,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_valid,
    input  logic [NB_DATA-1:0]              i_conv_data,
    input  logic                            i_sof,
    input  logic                            i_clear,
    output logic [NB_DATA-1:0]              o_tdata,
    output logic                            o_tvalid,
    output logic                            o_tlast,
    input  logic                            i_tready,
    output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level,
    output logic                            o_overflow
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int SKW = (SKIP_WORDS > 1) ? $clog2(SKIP_WORDS) : 1;
    localparam int OCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    localparam logic [SKW-1:0] SKIP_LAST  = (SKIP_WORDS > 0) ? SKW'(SKIP_WORDS - 1) : '0;
    localparam logic [OCW-1:0] FRAME_LAST = OCW'(FRAME_WORDS - 1);
    localparam logic [LW-1:0]  FULL_LEVEL = LW'(FIFO_DEPTH);

    typedef enum logic {
        ST_SKIP,
        ST_PASS
    } state_t;

    // With no warm-up words a frame starts directly in the forwarding state.
    localparam state_t ST_INIT = (SKIP_WORDS == 0) ? ST_PASS : ST_SKIP;

    logic [CONV_LATENCY-1:0] vdly;
    logic                    dvalid;

    state_t                  state;
    state_t                  cur_state;
    logic [SKW-1:0]          skip_cnt;
    logic [SKW-1:0]          cur_skip;
    logic [OCW-1:0]          out_cnt;
    logic [OCW-1:0]          cur_out;
    logic                    push;
    logic                    push_last;

    logic [NB_DATA:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW-1:0]           rd_ptr_next;
    logic [LW-1:0]           level;
    logic [LW-1:0]           level_next;
    logic [NB_DATA:0]        head_q;
    logic [NB_DATA:0]        head_next;
    logic                    full;
    logic                    pop;
    logic                    accept;
    logic                    drop;

    assign dvalid = vdly[CONV_LATENCY-1];

    // Shift i_valid through the same number of stages as the convolver pipeline.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            vdly <= '0;
        end else begin
            vdly[0] <= i_valid;
            for (int i = 1; i < CONV_LATENCY; i++) begin
                vdly[i] <= vdly[i-1];
            end
        end
    end

    // A start-of-frame pulse makes this cycle's word behave as the first of a new frame.
    always_comb begin
        cur_state = state;
        cur_skip  = skip_cnt;
        cur_out   = out_cnt;
        if (i_sof) begin
            cur_state = ST_INIT;
            cur_skip  = '0;
            cur_out   = '0;
        end
    end

    assign push      = dvalid && (cur_state == ST_PASS);
    assign push_last = (cur_out == FRAME_LAST);

    // Frame FSM: count warm-up words, then count forwarded words up to end of frame.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= ST_INIT;
            skip_cnt <= '0;
            out_cnt  <= '0;
        end else begin
            state    <= cur_state;
            skip_cnt <= cur_skip;
            out_cnt  <= cur_out;
            if (dvalid) begin
                if (cur_state == ST_SKIP) begin
                    if (cur_skip == SKIP_LAST) begin
                        skip_cnt <= '0;
                        state    <= ST_PASS;
                    end else begin
                        skip_cnt <= cur_skip + 1'b1;
                    end
                end else begin
                    if (push_last) begin
                        out_cnt <= '0;
                        state   <= ST_INIT;
                    end else begin
                        out_cnt <= cur_out + 1'b1;
                    end
                end
            end
        end
    end

    assign full   = (level == FULL_LEVEL);
    assign pop    = (level != '0) && i_tready;
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    assign rd_ptr_next = pop ? rd_ptr + 1'b1 : rd_ptr;

    // Next occupancy after this cycle's push and pop.
    always_comb begin
        level_next = level;
        if (accept && !pop) begin
            level_next = level + 1'b1;
        end else if (pop && !accept) begin
            level_next = level - 1'b1;
        end
    end

    // Next head word; a word written into an empty slot that becomes the head is taken from the push.
    always_comb begin
        head_next = head_q;
        if (level_next != '0) begin
            if (accept && (wr_ptr == rd_ptr_next)) begin
                head_next = {push_last, i_conv_data};
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    // FIFO storage; contents are qualified by the level, so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            mem[wr_ptr] <= {push_last, i_conv_data};
        end
    end

    // FIFO pointers, occupancy, registered head and the sticky overflow flag.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            head_q     <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_next;
            level  <= level_next;
            head_q <= head_next;
            if (drop) begin
                o_overflow <= 1'b1;
            end else if (i_clear) begin
                o_overflow <= 1'b0;
            end
        end
    end

    assign o_tvalid     = (level != '0);
    assign o_tdata      = head_q[NB_DATA-1:0];
    assign o_tlast      = head_q[NB_DATA] && o_tvalid;
    assign o_fifo_level = level;

endmodule

// File: tb/tb_conv_stream_out.sv
// Directed testbench for conv_stream_out with a short frame geometry:
// latency 2, two warm-up words, four words per frame, four FIFO entries.
module tb_conv_stream_out;

    localparam int NB    = 32;
    localparam int LAT   = 2;
    localparam int SKIP  = 2;
    localparam int FRAME = 4;
    localparam int DEPTH = 4;

    logic          i_clk;
    logic          i_reset;
    logic          i_valid;
    logic [NB-1:0] i_conv_data;
    logic          i_sof;
    logic          i_clear;
    logic [NB-1:0] o_tdata;
    logic          o_tvalid;
    logic          o_tlast;
    logic          i_tready;
    logic [2:0]    o_fifo_level;
    logic          o_overflow;

    int n_vec = 0;
    int n_err = 0;

    logic [NB-1:0] hist0;
    logic [NB-1:0] hist1;
    logic [NB:0]   rx_q[$];

    conv_stream_out #(
        .NB_DATA      (NB),
        .CONV_LATENCY (LAT),
        .SKIP_WORDS   (SKIP),
        .FRAME_WORDS  (FRAME),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .i_conv_data  (i_conv_data),
        .i_sof        (i_sof),
        .i_clear      (i_clear),
        .o_tdata      (o_tdata),
        .o_tvalid     (o_tvalid),
        .o_tlast      (o_tlast),
        .i_tready     (i_tready),
        .o_fifo_level (o_fifo_level),
        .o_overflow   (o_overflow)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // One clock cycle: the pixel presented with v reaches i_conv_data LAT cycles later,
    // like the real convolver; handshakes are recorded before the edge.
    task automatic tick(input logic v, input logic [NB-1:0] pix, input logic rdy);
        i_valid     = v;
        i_tready    = rdy;
        i_conv_data = hist1;
        hist1       = hist0;
        hist0       = pix;
        if (o_tvalid && rdy) rx_q.push_back({o_tlast, o_tdata});
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset;
        i_reset     = 1'b0;
        i_valid     = 1'b0;
        i_sof       = 1'b0;
        i_clear     = 1'b0;
        i_tready    = 1'b0;
        i_conv_data = '0;
        hist0       = '0;
        hist1       = '0;
        rx_q.delete();
        #3;
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset;
        do_reset;
        for (int k = 0; k < 10; k++) tick(1'b1, 32'h1000 + k, 1'b0);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        n_vec++; if (o_overflow !== 1'b1) begin n_err++; $display("[TB] FAIL reset_pre_ovf got %b want 1", o_overflow); end
        n_vec++; if (o_fifo_level !== 3'd4) begin n_err++; $display("[TB] FAIL reset_pre_level got %0d want 4", o_fifo_level); end
        #2;
        i_reset = 1'b0;
        #1;
        n_vec++; if (o_tvalid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_tvalid got %b want 0", o_tvalid); end
        n_vec++; if (o_tlast !== 1'b0) begin n_err++; $display("[TB] FAIL reset_tlast got %b want 0", o_tlast); end
        n_vec++; if (o_tdata !== 32'h0) begin n_err++; $display("[TB] FAIL reset_tdata got %h want 0", o_tdata); end
        n_vec++; if (o_fifo_level !== 3'd0) begin n_err++; $display("[TB] FAIL reset_level got %0d want 0", o_fifo_level); end
        n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ovf got %b want 0", o_overflow); end
        #1;
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        for (int k = 0; k < 3; k++) tick(1'b0, '0, 1'b1);
        n_vec++; if (o_tvalid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_after_tvalid got %b want 0", o_tvalid); end
    endtask

    task automatic test_basic_frame;
        logic exp_v;
        do_reset;
        for (int k = 0; k < 10; k++) begin
            tick(k < 6, 32'hA0 + k, 1'b1);
            exp_v = (k >= 4) && (k <= 7);
            n_vec++; if (o_tvalid !== exp_v) begin n_err++; $display("[TB] FAIL basic_tvalid[%0d] got %b want %b", k, o_tvalid, exp_v); end
            if (exp_v) begin
                n_vec++; if (o_tdata !== 32'hA0 + k - 2) begin n_err++; $display("[TB] FAIL basic_tdata[%0d] got %h want %h", k, o_tdata, 32'hA0 + k - 2); end
                n_vec++; if (o_tlast !== (k == 7)) begin n_err++; $display("[TB] FAIL basic_tlast[%0d] got %b want %b", k, o_tlast, (k == 7)); end
            end else begin
                n_vec++; if (o_tlast !== 1'b0) begin n_err++; $display("[TB] FAIL basic_tlast_idle[%0d] got %b want 0", k, o_tlast); end
            end
        end
    endtask

    task automatic test_overflow;
        do_reset;
        for (int k = 0; k < 9; k++) tick(1'b1, 32'hB0 + k, 1'b0);
        n_vec++; if (o_fifo_level !== 3'd4) begin n_err++; $display("[TB] FAIL ovf_level_full got %0d want 4", o_fifo_level); end
        n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("[TB] FAIL ovf_before_drop got %b want 0", o_overflow); end
        n_vec++; if (o_tdata !== 32'hB2) begin n_err++; $display("[TB] FAIL ovf_head got %h want b2", o_tdata); end
        n_vec++; if (o_tlast !== 1'b0) begin n_err++; $display("[TB] FAIL ovf_head_last got %b want 0", o_tlast); end
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        n_vec++; if (o_overflow !== 1'b1) begin n_err++; $display("[TB] FAIL ovf_after_drop got %b want 1", o_overflow); end
        n_vec++; if (o_fifo_level !== 3'd4) begin n_err++; $display("[TB] FAIL ovf_level_after_drop got %0d want 4", o_fifo_level); end
        i_clear = 1'b1;
        tick(1'b0, '0, 1'b0);
        i_clear = 1'b0;
        n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("[TB] FAIL ovf_clear got %b want 0", o_overflow); end
        tick(1'b1, 32'hB9, 1'b0);
        tick(1'b0, '0, 1'b0);
        i_clear = 1'b1;
        tick(1'b0, '0, 1'b0);
        i_clear = 1'b0;
        n_vec++; if (o_overflow !== 1'b1) begin n_err++; $display("[TB] FAIL ovf_set_wins got %b want 1", o_overflow); end
        i_clear = 1'b1;
        tick(1'b0, '0, 1'b0);
        i_clear = 1'b0;
        n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("[TB] FAIL ovf_clear2 got %b want 0", o_overflow); end
        n_vec++; if (o_tdata !== 32'hB2) begin n_err++; $display("[TB] FAIL ovf_head_kept got %h want b2", o_tdata); end
    endtask

    task automatic test_full_push_pop;
        logic [NB:0] exp_q[$];
        do_reset;
        for (int k = 0; k < 9; k++) tick(1'b1, 32'hC0 + k, 1'b0);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b1);
        n_vec++; if (o_fifo_level !== 3'd4) begin n_err++; $display("[TB] FAIL fpp_level got %0d want 4", o_fifo_level); end
        n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("[TB] FAIL fpp_ovf got %b want 0", o_overflow); end
        n_vec++; if (o_tdata !== 32'hC3) begin n_err++; $display("[TB] FAIL fpp_head got %h want c3", o_tdata); end
        for (int k = 0; k < 4; k++) tick(1'b0, '0, 1'b1);
        exp_q = '{{1'b0, 32'hC2}, {1'b0, 32'hC3}, {1'b0, 32'hC4}, {1'b1, 32'hC5}, {1'b0, 32'hC8}};
        n_vec++; if (rx_q.size() !== exp_q.size()) begin n_err++; $display("[TB] FAIL fpp_count got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int j = 0; j < exp_q.size() && j < rx_q.size(); j++) begin
            n_vec++; if (rx_q[j] !== exp_q[j]) begin n_err++; $display("[TB] FAIL fpp_word[%0d] got %h want %h", j, rx_q[j], exp_q[j]); end
        end
        n_vec++; if (o_tvalid !== 1'b0) begin n_err++; $display("[TB] FAIL fpp_empty_tvalid got %b want 0", o_tvalid); end
        n_vec++; if (o_tlast !== 1'b0) begin n_err++; $display("[TB] FAIL fpp_empty_tlast got %b want 0", o_tlast); end
        n_vec++; if (o_tdata !== 32'hC8) begin n_err++; $display("[TB] FAIL fpp_hold_tdata got %h want c8", o_tdata); end
    endtask

    task automatic test_sof;
        logic [NB:0] exp_q[$];
        do_reset;
        for (int k = 0; k < 4; k++) tick(1'b1, 32'hE0 + k, 1'b1);
        for (int k = 0; k < 3; k++) tick(1'b0, '0, 1'b1);
        i_sof = 1'b1;
        tick(1'b0, '0, 1'b1);
        i_sof = 1'b0;
        for (int k = 0; k < 6; k++) tick(1'b1, 32'hF0 + k, 1'b1);
        for (int k = 0; k < 4; k++) tick(1'b0, '0, 1'b1);
        exp_q = '{{1'b0, 32'hE2}, {1'b0, 32'hE3}, {1'b0, 32'hF2}, {1'b0, 32'hF3}, {1'b0, 32'hF4}, {1'b1, 32'hF5}};
        n_vec++; if (rx_q.size() !== exp_q.size()) begin n_err++; $display("[TB] FAIL sof_count got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int j = 0; j < exp_q.size() && j < rx_q.size(); j++) begin
            n_vec++; if (rx_q[j] !== exp_q[j]) begin n_err++; $display("[TB] FAIL sof_word[%0d] got %h want %h", j, rx_q[j], exp_q[j]); end
        end
    endtask

    task automatic test_stall_stability;
        logic [NB:0]   exp_q[$];
        int            k;
        int            v1;
        int            v2;
        logic          v;
        logic          rdy;
        logic          pv;
        logic          prdy;
        logic [NB-1:0] pd;
        logic          pl;
        do_reset;
        k  = 0;
        v1 = 0;
        v2 = 0;
        for (int cyc = 0; cyc < 600 && (k < 24 || rx_q.size() < 16); cyc++) begin
            rdy  = ($urandom_range(0, 2) != 0);
            v    = (k < 24) && (int'(o_fifo_level) + v1 + v2 + 1 <= DEPTH);
            pv   = o_tvalid;
            prdy = rdy;
            pd   = o_tdata;
            pl   = o_tlast;
            tick(v, 32'(k), rdy);
            if (v) k++;
            v2 = v1;
            v1 = int'(v);
            if (pv && !prdy) begin
                n_vec++; if (o_tvalid !== 1'b1) begin n_err++; $display("[TB] FAIL stall_tvalid[%0d] got %b want 1", cyc, o_tvalid); end
                n_vec++; if (o_tdata !== pd) begin n_err++; $display("[TB] FAIL stall_tdata[%0d] got %h want %h", cyc, o_tdata, pd); end
                n_vec++; if (o_tlast !== pl) begin n_err++; $display("[TB] FAIL stall_tlast[%0d] got %b want %b", cyc, o_tlast, pl); end
            end
        end
        for (int kk = 0; kk < 24; kk++) begin
            if ((kk % 6) >= 2) exp_q.push_back({((kk % 6) == 5), 32'(kk)});
        end
        n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("[TB] FAIL stall_ovf got %b want 0", o_overflow); end
        n_vec++; if (rx_q.size() !== exp_q.size()) begin n_err++; $display("[TB] FAIL stall_count got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int j = 0; j < exp_q.size() && j < rx_q.size(); j++) begin
            n_vec++; if (rx_q[j] !== exp_q[j]) begin n_err++; $display("[TB] FAIL stall_word[%0d] got %h want %h", j, rx_q[j], exp_q[j]); end
        end
    endtask

    initial begin
        test_reset;
        test_basic_frame;
        test_overflow;
        test_full_push_pop;
        test_sof;
        test_stall_stability;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
